packet_injector: RTL

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/noc_params.sv | 45 ++++
 rtl/desc_queue.sv | 46 ++++
 rtl/packet_injector.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// Shared NoC definitions: flit format, virtual-channel count and the
// packet descriptor used by the traffic injector.
package noc_params;

    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
    // Descriptor length field: $clog2(8)+1 for the default maximum of 8 flits.
    localparam int DESC_LEN_W        = 4;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [DESC_LEN_W-1:0]       len;
        logic [FLIT_DATA_SIZE-1:0]   pl_seed;
    } pkt_desc_t;

endpackage

// File: rtl/desc_queue.sv
// Small power-of-two FIFO holding packet descriptors for the injector.
// Head entry is visible combinationally on data_o while non-empty.
module desc_queue
    import noc_params::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  pkt_desc_t data_i,
    output pkt_desc_t data_o,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    pkt_desc_t      r_mem [DEPTH];

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign data_o = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Advance read/write pointers; a push while full is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array: written on accepted pushes, never cleared.
    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/packet_injector.sv
// Packet injector: queues descriptors, allocates a virtual channel by
// round-robin and streams the packet's flits into the router local port.
module packet_injector
    import noc_params::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  pkt_desc_t         req_desc_i,
    output flit_t             data_o,
    output logic              is_valid_o,
    input  logic [VC_NUM-1:0] is_on_off_i,
    input  logic [VC_NUM-1:0] is_allocatable_i,
    output logic              busy_o,
    output logic              pkt_sent_o
);

    localparam int LEN_W = $clog2(MAX_PKT_LEN) + 1;

    typedef enum logic [1:0] {IDLE, ALLOC, SEND} state_t;

    state_t                        r_state, w_state;
    logic [VC_SIZE-1:0]            r_rr_ptr, w_rr_ptr;
    logic [VC_SIZE-1:0]            r_vc, w_vc;
    logic [DEST_ADDR_SIZE_X-1:0]   r_x, w_x;
    logic [DEST_ADDR_SIZE_Y-1:0]   r_y, w_y;
    logic [FLIT_DATA_SIZE-1:0]     r_seed, w_seed;
    logic [LEN_W-1:0]              r_len, w_len;
    logic [LEN_W-1:0]              r_idx, w_idx;
    flit_t                         r_data, w_data;
    logic                          r_valid, w_valid;
    logic                          r_sent, w_sent;

    logic                          w_push, w_pop, w_full, w_empty;
    pkt_desc_t                     w_q_desc;
    logic [VC_NUM-1:0]             w_cand;
    logic                          w_grant;
    logic [VC_SIZE-1:0]            w_gnt_vc;

    // Zero-length packets become single-flit packets; oversize ones are clipped.
    function automatic logic [LEN_W-1:0] sat_len(input logic [DESC_LEN_W-1:0] len);
        if (len == '0)                      return LEN_W'(1);
        else if (int'(len) > MAX_PKT_LEN)   return LEN_W'(MAX_PKT_LEN);
        else                                return LEN_W'(len);
    endfunction

    assign w_push      = req_valid_i && req_ready_o;
    assign req_ready_o = !w_full;
    assign busy_o      = (r_state != IDLE) || !w_empty;
    assign data_o      = r_data;
    assign is_valid_o  = r_valid;
    assign pkt_sent_o  = r_sent;

    desc_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .pop    (w_pop),
        .data_i (req_desc_i),
        .data_o (w_q_desc),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Next-state, VC arbitration and next-flit formation.
    always_comb begin
        int j;
        j        = 0;
        w_state  = r_state;
        w_rr_ptr = r_rr_ptr;
        w_vc     = r_vc;
        w_x      = r_x;
        w_y      = r_y;
        w_seed   = r_seed;
        w_len    = r_len;
        w_idx    = r_idx;
        w_data   = r_data;
        w_valid  = 1'b0;
        w_sent   = 1'b0;
        w_pop    = 1'b0;
        w_cand   = is_allocatable_i & is_on_off_i;
        w_grant  = 1'b0;
        w_gnt_vc = '0;

        // Scan downward so the candidate closest to rr_ptr is the last one kept.
        for (int k = VC_NUM - 1; k >= 0; k--) begin
            j = (int'(r_rr_ptr) + k) % VC_NUM;
            if (w_cand[j]) begin
                w_grant  = 1'b1;
                w_gnt_vc = VC_SIZE'(j);
            end
        end

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    w_x     = w_q_desc.x_dest;
                    w_y     = w_q_desc.y_dest;
                    w_seed  = w_q_desc.pl_seed;
                    w_len   = sat_len(w_q_desc.len);
                    w_state = ALLOC;
                end
            end
            ALLOC: begin
                if (w_grant) begin
                    w_valid                        = 1'b1;
                    w_vc                           = w_gnt_vc;
                    w_rr_ptr                       = VC_SIZE'((int'(w_gnt_vc) + 1) % VC_NUM);
                    w_idx                          = LEN_W'(1);
                    w_data.vc_id                   = w_gnt_vc;
                    w_data.data.head_data.x_dest   = r_x;
                    w_data.data.head_data.y_dest   = r_y;
                    w_data.data.head_data.head_pl  = r_seed[HEAD_PAYLOAD_SIZE-1:0];
                    if (r_len <= LEN_W'(1)) begin
                        w_data.flit_label = HEADTAIL;
                        w_sent            = 1'b1;
                        w_state           = IDLE;
                    end else begin
                        w_data.flit_label = HEAD;
                        w_state           = SEND;
                    end
                end
            end
            SEND: begin
                if (is_on_off_i[r_vc]) begin
                    w_valid          = 1'b1;
                    w_idx            = r_idx + LEN_W'(1);
                    w_data.vc_id     = r_vc;
                    w_data.data.bt_pl = r_seed + FLIT_DATA_SIZE'(r_idx);
                    if (r_idx == r_len - LEN_W'(1)) begin
                        w_data.flit_label = TAIL;
                        w_sent            = 1'b1;
                        w_state           = IDLE;
                    end else begin
                        w_data.flit_label = BODY;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_valid  <= 1'b0;
            r_sent   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state;
            r_rr_ptr <= w_rr_ptr;
            r_valid  <= w_valid;
            r_sent   <= w_sent;
            r_data   <= w_data;
        end
    end

    // Working copy of the packet in flight; reloaded on every pop.
    always_ff @(posedge clk) begin
        r_vc   <= w_vc;
        r_x    <= w_x;
        r_y    <= w_y;
        r_seed <= w_seed;
        r_len  <= w_len;
        r_idx  <= w_idx;
    end

endmodule
